// File: rtl/change_dispenser_if.sv
// Handshake bundle between a change requester (master) and the change dispenser (slave).
// Covers the request, stock reload, hopper handshake and status/stock readback.
interface change_dispenser_if;
    logic       req;
    logic [3:0] amount;
    logic       load;
    logic [3:0] load_50;
    logic [5:0] load_10;
    logic       hopper_ack;
    logic       coin_50;
    logic       coin_10;
    logic       busy;
    logic       done;
    logic       reject;
    logic       fault;
    logic [3:0] stock_50;
    logic [5:0] stock_10;

    modport master (
        output req, amount, load, load_50, load_10, hopper_ack,
        input  coin_50, coin_10, busy, done, reject, fault, stock_50, stock_10
    );

    modport slave (
        input  req, amount, load, load_50, load_10, hopper_ack,
        output coin_50, coin_10, busy, done, reject, fault, stock_50, stock_10
    );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: pays an amount in $50 coins first, then $10 coins, one hopper-acknowledged
// coin at a time; refuses requests the stock cannot cover and latches a fault on hopper timeout.
module change_dispenser #(
    parameter int ACK_TIMEOUT = 8
) (
    input logic               clk,
    input logic               reset,
    change_dispenser_if.slave cd
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, CALC, PAY50, WAIT50, PAY10, WAIT10, DONE, FAULT
    } state_t;

    state_t           state;
    logic [3:0]       remaining;
    logic [3:0]       n50;
    logic [3:0]       n10;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       stock_50;
    logic [5:0]       stock_10;
    logic             coin_50;
    logic             coin_10;
    logic             busy;
    logic             done;
    logic             reject;
    logic             fault;

    logic [3:0]       calc_n50;
    logic [3:0]       calc_n10;
    logic             calc_short;
    logic [3:0]       n50_left;
    logic [3:0]       n10_left;

    function automatic logic [3:0] sat_add_50(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[4] ? 4'd15 : s[3:0];
    endfunction

    function automatic logic [5:0] sat_add_10(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[6] ? 6'd63 : s[5:0];
    endfunction

    function automatic logic [3:0] min4(input logic [3:0] a, input logic [3:0] b);
        return (a < b) ? a : b;
    endfunction

    // Coin split: as many $50 as both the amount and the stock allow, remainder in $10.
    always_comb begin
        calc_n50   = min4(remaining / 4'd5, stock_50);
        calc_n10   = remaining - calc_n50 * 4'd5;
        calc_short = {2'b00, calc_n10} > stock_10;
    end

    assign n50_left = n50 - 4'd1;
    assign n10_left = n10 - 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            n50       <= '0;
            n10       <= '0;
            wait_cnt  <= '0;
            stock_50  <= '0;
            stock_10  <= '0;
            coin_50   <= 1'b0;
            coin_10   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            reject    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            coin_50 <= 1'b0;
            coin_10 <= 1'b0;
            done    <= 1'b0;
            reject  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cd.req) begin
                        remaining <= cd.amount;
                        busy      <= 1'b1;
                        state     <= CALC;
                    end else if (cd.load) begin
                        stock_50 <= sat_add_50(stock_50, cd.load_50);
                        stock_10 <= sat_add_10(stock_10, cd.load_10);
                    end
                end
                CALC: begin
                    if (calc_short) begin
                        reject <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        n50 <= calc_n50;
                        n10 <= calc_n10;
                        if (calc_n50 != 4'd0) begin
                            coin_50 <= 1'b1;
                            state   <= PAY50;
                        end else if (calc_n10 != 4'd0) begin
                            coin_10 <= 1'b1;
                            state   <= PAY10;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                PAY50: begin
                    wait_cnt <= '0;
                    state    <= WAIT50;
                end
                // Stock only moves on an acknowledged coin, so a fault leaves it exact.
                WAIT50: begin
                    if (cd.hopper_ack) begin
                        stock_50 <= stock_50 - 4'd1;
                        n50      <= n50_left;
                        if (n50_left != 4'd0) begin
                            coin_50 <= 1'b1;
                            state   <= PAY50;
                        end else if (n10 != 4'd0) begin
                            coin_10 <= 1'b1;
                            state   <= PAY10;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end else if (wait_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        fault <= 1'b1;
                        busy  <= 1'b0;
                        state <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                PAY10: begin
                    wait_cnt <= '0;
                    state    <= WAIT10;
                end
                WAIT10: begin
                    if (cd.hopper_ack) begin
                        stock_10 <= stock_10 - 6'd1;
                        n10      <= n10_left;
                        if (n10_left != 4'd0) begin
                            coin_10 <= 1'b1;
                            state   <= PAY10;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end else if (wait_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        fault <= 1'b1;
                        busy  <= 1'b0;
                        state <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cd.coin_50  = coin_50;
    assign cd.coin_10  = coin_10;
    assign cd.busy     = busy;
    assign cd.done     = done;
    assign cd.reject   = reject;
    assign cd.fault    = fault;
    assign cd.stock_50 = stock_50;
    assign cd.stock_10 = stock_10;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus randomized requests checked against
// a coin-count model of the stock (greedy $50 split, all-or-nothing payment).
module tb_change_dispenser;
    localparam int ACK_TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   m50 = 0;
    int   m10 = 0;

    change_dispenser_if cd();

    change_dispenser #(.ACK_TIMEOUT(ACK_TO)) dut (
        .clk   (clk),
        .reset (reset),
        .cd    (cd.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {16'd0, cd.coin_50, cd.coin_10, cd.busy, cd.done, cd.reject, cd.fault,
                cd.stock_50, cd.stock_10};
    endfunction

    task automatic clear_inputs();
        cd.req = 1'b0; cd.amount = 4'd0; cd.load = 1'b0;
        cd.load_50 = 4'd0; cd.load_10 = 6'd0; cd.hopper_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk("reset_outputs", outs(), 0);
        reset = 1'b0;
        m50 = 0;
        m10 = 0;
    endtask

    task automatic do_load(input int l50, input int l10);
        cd.load = 1'b1; cd.load_50 = l50[3:0]; cd.load_10 = l10[5:0];
        tick();
        clear_inputs();
        m50 = (m50 + l50 > 15) ? 15 : m50 + l50;
        m10 = (m10 + l10 > 63) ? 63 : m10 + l10;
        chk("load_stock_50", cd.stock_50, m50);
        chk("load_stock_10", cd.stock_10, m10);
    endtask

    // One request from IDLE to its outcome; d = cycles from coin pulse to ack.
    task automatic run_req(input int amt, input int d, input bit noise, input bit with_load);
        int  e50, e10, cyc, ack_cyc, outcome, c50, c10;
        bit  erej, order_bad, both, busy_bad;
        e50 = amt / 5;
        if (e50 > m50) e50 = m50;
        e10  = amt - 5 * e50;
        erej = (e10 > m10);
        cyc = 0; ack_cyc = -1; outcome = 0; c50 = 0; c10 = 0;
        order_bad = 0; both = 0; busy_bad = 0;
        cd.req = 1'b1; cd.amount = amt[3:0];
        if (with_load) begin
            cd.load = 1'b1; cd.load_50 = 4'd5; cd.load_10 = 6'd5;
        end
        tick();
        clear_inputs();
        chk("calc_busy", cd.busy, 1);
        while (outcome == 0 && cyc < 400) begin
            tick();
            cyc++;
            if (cd.coin_50 && cd.coin_10) both = 1;
            if (cd.coin_50) begin
                c50++;
                if (c10 > 0) order_bad = 1;
                ack_cyc = cyc + d;
            end
            if (cd.coin_10) begin
                c10++;
                ack_cyc = cyc + d;
            end
            if (cd.done) outcome = 1;
            else if (cd.reject) outcome = 2;
            else if (cd.fault) outcome = 3;
            else if (!cd.busy) busy_bad = 1;
            if (outcome != 0) begin
                clear_inputs();
            end else begin
                cd.hopper_ack = (cyc == ack_cyc);
                if (noise) begin
                    cd.req = 1'($urandom); cd.amount = 4'($urandom);
                    cd.load = 1'($urandom); cd.load_50 = 4'($urandom); cd.load_10 = 6'($urandom);
                end
            end
        end
        chk("outcome", outcome, erej ? 2 : 1);
        chk("n_coin_50", c50, erej ? 0 : e50);
        chk("n_coin_10", c10, erej ? 0 : e10);
        chk("coin_order", order_bad, 0);
        chk("coin_overlap", both, 0);
        chk("busy_held", busy_bad, 0);
        if (erej || amt == 0) chk("outcome_latency", cyc, 1);
        if (!erej) begin
            m50 -= e50;
            m10 -= e10;
        end
        chk("stock_50", cd.stock_50, m50);
        chk("stock_10", cd.stock_10, m10);
        tick();
    endtask

    initial begin
        int c, pend, pulse_cyc, fault_cyc, stray;
        clear_inputs();
        do_reset();

        // Basic payout with acks two cycles after each pulse.
        do_load(3, 10);
        run_req(7, 2, 0, 0);
        chk("ex1_stock_50", cd.stock_50, 2);
        chk("ex1_stock_10", cd.stock_10, 8);

        run_req(0, 1, 0, 0);

        // Insufficient $10 stock is refused whole, then a payout that drains everything.
        do_reset();
        do_load(0, 3);
        run_req(4, 1, 0, 0);
        do_load(1, 4);
        run_req(12, 2, 0, 0);
        chk("drain_stock", {cd.stock_50, cd.stock_10}, 0);

        // Simultaneous load dropped, busy-time strobes ignored, ack on the last allowed cycle.
        do_load(3, 20);
        run_req(6, 1, 0, 1);
        run_req(9, 3, 1, 0);
        run_req(2, ACK_TO, 0, 0);

        // Hopper never acknowledges: fault after the timeout, then everything is ignored.
        do_reset();
        do_load(0, 5);
        cd.req = 1'b1; cd.amount = 4'd1;
        tick();
        clear_inputs();
        pulse_cyc = -1; fault_cyc = -1;
        for (int i = 1; i < 60 && fault_cyc < 0; i++) begin
            tick();
            if (cd.coin_10) pulse_cyc = i;
            if (cd.fault) fault_cyc = i;
        end
        chk("fault_pulse_seen", pulse_cyc, 1);
        chk("fault_delay", fault_cyc - pulse_cyc, ACK_TO + 1);
        chk("fault_busy", cd.busy, 0);
        chk("fault_stock_10", cd.stock_10, 5);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            cd.req = 1'b1; cd.amount = 4'd3; cd.load = 1'b1;
            cd.load_50 = 4'd2; cd.load_10 = 6'd2; cd.hopper_ack = 1'b1;
            tick();
            if (cd.coin_50 || cd.coin_10 || cd.done || cd.reject || cd.busy) stray++;
        end
        clear_inputs();
        chk("fault_ignores_inputs", stray, 0);
        chk("fault_sticky", cd.fault, 1);
        chk("fault_stock_hold", {cd.stock_50, cd.stock_10}, {4'd0, 6'd5});

        // Reset in the middle of a five-coin payout.
        do_reset();
        do_load(0, 10);
        cd.req = 1'b1; cd.amount = 4'd5;
        tick();
        clear_inputs();
        c = 0; pend = 0;
        for (int i = 0; i < 100 && c < 3; i++) begin
            tick();
            cd.hopper_ack = pend[0];
            pend = 0;
            if (cd.coin_10) begin
                c++;
                pend = 1;
            end
        end
        chk("abort_pulses", c, 3);
        tick();
        cd.hopper_ack = 1'b0;
        chk("abort_pre_stock", cd.stock_10, 8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m50 = 0; m10 = 0;
        chk("abort_outputs", outs(), 0);
        do_load(2, 3);
        run_req(8, 1, 0, 0);

        // Randomized requests against the stock model.
        do_reset();
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 2) == 0 || m10 < 4)
                do_load($urandom_range(0, 15), $urandom_range(0, 63));
            run_req($urandom_range(0, 15), $urandom_range(1, ACK_TO), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
